// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// Holds FSM state type, default geometry and WB field positions.
package mem_stage_pkg;

   typedef enum logic {
      IDLE,
      WAIT
   } state_t;

   localparam int DEF_DEPTH = 32;
   localparam int DEF_LAT   = 3;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   function automatic logic [1:0] wb_pack(
      input logic reg_write,
      input logic mem_to_reg
   );
      logic [1:0] w;
      w = '0;
      w[WB_REGWRITE] = reg_write;
      w[WB_MEMTOREG] = mem_to_reg;
      return w;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 data memory: one synchronous write, one async read, no reset.
// Ports: clk, we, addr (word index), wdata in; rdata out.
module dmem_array
   import mem_stage_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: variable-latency word access to local dmem, MEM/WB register.
// In: clk_i, rst_i (sync, high), mem_read_i, mem_write_i, addr_i, wdata_i,
//     WB_i, rd_i. Out: WB_o, rdata_o, ALU_o, rd_o, stall_o (comb), err_o.
// Option: DMEM_ALIGN_CHECK_EN enables the sticky misaligned-access flag.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int LAT   = DEF_LAT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  WB_i,
   input  logic [4:0]  rd_i,
   output logic [1:0]  WB_o,
   output logic [31:0] rdata_o,
   output logic [31:0] ALU_o,
   output logic [4:0]  rd_o,
   output logic        stall_o,
   output logic        err_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LAT) + 1;
   localparam logic [CW-1:0] LAST = CW'(LAT - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          req;
   logic          done;
   logic          mis;
   logic          we;
   logic [AW-1:0] idx;
   logic [31:0]   rd_word;

   assign req = mem_read_i | mem_write_i;
   assign idx = addr_i[AW+1:2];

   // Completion: first cycle when LAT is 1, else last WAIT cycle.
   assign done = (state == IDLE) ? (LAT == 1) : (cnt == LAST);

   assign stall_o = !rst_i && req && !done;

`ifdef DMEM_ALIGN_CHECK_EN
   assign mis = |addr_i[1:0];
`else
   assign mis = 1'b0;
   assign err_o = 1'b0;
`endif

   assign we = !rst_i && req && done && mem_write_i && !mis;

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_dmem (
      .clk   (clk_i),
      .we    (we),
      .addr  (idx),
      .wdata (wdata_i),
      .rdata (rd_word)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         cnt     <= '0;
         WB_o    <= '0;
         rdata_o <= '0;
         ALU_o   <= '0;
         rd_o    <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
         err_o   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (req && !done) begin
                  state <= WAIT;
                  cnt   <= CW'(1);
               end
            end
            WAIT: begin
               if (done) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
         endcase

         if (stall_o) begin
            WB_o <= wb_pack(1'b0, 1'b0);
         end else begin
            WB_o  <= WB_i;
            ALU_o <= addr_i;
            rd_o  <= rd_i;
            // Write wins over read, and a store leaves 0 as load data.
            if (mem_write_i) begin
               rdata_o <= '0;
            end else if (mem_read_i) begin
               rdata_o <= mis ? 32'h0 : rd_word;
            end
`ifdef DMEM_ALIGN_CHECK_EN
            if (req && mis) begin
               err_o <= 1'b1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a LAT=3 and a LAT=1 instance.
// Driver pushes per-cycle expectations; a monitor pops and compares.
module tb_mem_stage;

   typedef struct packed {
      logic        rst;
      logic        rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [1:0]  wb;
      logic [4:0]  r;
   } in_t;

   typedef struct {
      int          due;
      int          d;
      logic [1:0]  wb;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        err;
   } ent_t;

`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   in_t inp [2];

   logic [1:0]  wb3, wb1;
   logic [31:0] rdata3, rdata1, alu3, alu1;
   logic [4:0]  rd3, rd1;
   logic        st3, st1, err3, err1;

   mem_stage #(.DEPTH(32), .LAT(3)) dut3 (
      .clk_i       (clk),
      .rst_i       (inp[0].rst),
      .mem_read_i  (inp[0].rd),
      .mem_write_i (inp[0].wr),
      .addr_i      (inp[0].a),
      .wdata_i     (inp[0].wd),
      .WB_i        (inp[0].wb),
      .rd_i        (inp[0].r),
      .WB_o        (wb3),
      .rdata_o     (rdata3),
      .ALU_o       (alu3),
      .rd_o        (rd3),
      .stall_o     (st3),
      .err_o       (err3)
   );

   mem_stage #(.DEPTH(32), .LAT(1)) dut1 (
      .clk_i       (clk),
      .rst_i       (inp[1].rst),
      .mem_read_i  (inp[1].rd),
      .mem_write_i (inp[1].wr),
      .addr_i      (inp[1].a),
      .wdata_i     (inp[1].wd),
      .WB_i        (inp[1].wb),
      .rd_i        (inp[1].r),
      .WB_o        (wb1),
      .rdata_o     (rdata1),
      .ALU_o       (alu1),
      .rd_o        (rd1),
      .stall_o     (st1),
      .err_o       (err1)
   );

   int total = 0;
   int bad = 0;

   ent_t        q [$];
   ent_t        m [2];
   int          left [2];
   int          lat [2] = '{3, 1};
   logic [31:0] mm [2][32];

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   // Inputs already applied at posedge+1; predict next-edge outputs.
   task automatic tick();
      logic       st_exp;
      logic       mis;
      int         idx;
      ent_t       e;
      #1;
      for (int d = 0; d < 2; d++) begin
         st_exp = 1'b0;
         idx = int'(inp[d].a[6:2]);
         mis = ALIGN && (inp[d].a[1:0] != 2'b00);
         if (inp[d].rst) begin
            left[d] = 0;
            m[d].wb = 2'b00;
            m[d].rdata = '0;
            m[d].alu = '0;
            m[d].rd = '0;
            m[d].err = 1'b0;
         end else if (inp[d].rd || inp[d].wr) begin
            if (left[d] == 0) left[d] = lat[d];
            left[d]--;
            if (left[d] != 0) begin
               st_exp = 1'b1;
               m[d].wb = 2'b00;
            end else begin
               m[d].wb = inp[d].wb;
               m[d].alu = inp[d].a;
               m[d].rd = inp[d].r;
               if (inp[d].wr) begin
                  if (!mis) mm[d][idx] = inp[d].wd;
                  m[d].rdata = '0;
               end else begin
                  m[d].rdata = mis ? 32'h0 : mm[d][idx];
               end
               if (mis) m[d].err = 1'b1;
            end
         end else begin
            m[d].wb = inp[d].wb;
            m[d].alu = inp[d].a;
            m[d].rd = inp[d].r;
         end
         chk($sformatf("stall%0d", d), {31'b0, (d == 0) ? st3 : st1},
             {31'b0, st_exp});
         e = m[d];
         e.due = cyc + 1;
         e.d = d;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set(input int d, input logic r_, input logic w_,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] wb, input logic [4:0] r);
      inp[d].rst = 1'b0;
      inp[d].rd = r_;
      inp[d].wr = w_;
      inp[d].a = a;
      inp[d].wd = wd;
      inp[d].wb = wb;
      inp[d].r = r;
   endtask

   task automatic idle(input int d);
      set(d, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 5'd0);
   endtask

   task automatic op(input int d, input logic r_, input logic w_,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] wb, input logic [4:0] r);
      set(d, r_, w_, a, wd, wb, r);
      repeat (lat[d]) tick();
   endtask

   // Monitor: compare every registered MEM/WB capture against the queue.
   initial begin
      ent_t e;
      forever begin
         @(posedge clk);
         #3;
         while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk($sformatf("wb%0d", e.d), {30'b0, e.d == 0 ? wb3 : wb1},
                {30'b0, e.wb});
            chk($sformatf("rdata%0d", e.d), e.d == 0 ? rdata3 : rdata1,
                e.rdata);
            chk($sformatf("alu%0d", e.d), e.d == 0 ? alu3 : alu1, e.alu);
            chk($sformatf("rd%0d", e.d), {27'b0, e.d == 0 ? rd3 : rd1},
                {27'b0, e.rd});
            chk($sformatf("err%0d", e.d), {31'b0, e.d == 0 ? err3 : err1},
                {31'b0, e.err});
         end
      end
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         inp[d] = '0;
         inp[d].rst = 1'b1;
         left[d] = 0;
      end
      @(posedge clk);
      #1;
      repeat (2) tick();
      idle(0);
      idle(1);
      tick();

      // LAT=3 store then load of same word
      op(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0);
      chk("mem4", dut3.u_dmem.mem[4], 32'hDEADBEEF);
      op(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd8);
      idle(0);
      tick();

      // seed 0x20 with 7, then wrap-around store/load back to back
      op(0, 1'b0, 1'b1, 32'h20, 32'h7, 2'b00, 5'd0);
      op(0, 1'b0, 1'b1, 32'h84, 32'hA5A5A5A5, 2'b00, 5'd0);
      op(0, 1'b1, 1'b0, 32'h04, 32'h0, 2'b11, 5'd5);
      idle(0);
      tick();

      // reset in second cycle of a store to 0x20
      set(0, 1'b0, 1'b1, 32'h20, 32'h1, 2'b00, 5'd2);
      tick();
      inp[0].rst = 1'b1;
      tick();
      idle(0);
      tick();
      chk("mem8", dut3.u_dmem.mem[8], 32'h7);
      op(0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 5'd6);
      idle(0);
      tick();

      // LAT=1: alternate ALU-type and memory ops, never stalls
      op(1, 1'b0, 1'b0, 32'h55, 32'h0, 2'b10, 5'd3);
      op(1, 1'b0, 1'b1, 32'h08, 32'h12345678, 2'b00, 5'd0);
      op(1, 1'b0, 1'b0, 32'h55, 32'h0, 2'b10, 5'd4);
      op(1, 1'b1, 1'b0, 32'h08, 32'h0, 2'b11, 5'd9);
      op(1, 1'b1, 1'b1, 32'h0C, 32'h99, 2'b00, 5'd1);
      op(1, 1'b1, 1'b0, 32'h0C, 32'h0, 2'b11, 5'd10);
      idle(1);
      tick();

`ifdef DMEM_ALIGN_CHECK_EN
      op(0, 1'b0, 1'b1, 32'h13, 32'hFFFF, 2'b00, 5'd0);
      chk("mem4_kept", dut3.u_dmem.mem[4], 32'hDEADBEEF);
      op(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd7);
      idle(0);
      repeat (2) tick();
      inp[0].rst = 1'b1;
      tick();
      idle(0);
      tick();
`endif

      repeat (3) tick();
      @(posedge clk);
      #4;
      chk("drain", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
